alu_result_checker: RTL and testbench
=====================================

// Module: alu_result_checker
// PURPOSE
//  Golden-model checker placed directly downstream of the 4-bit trojan ALU (ops ADD/SUB/AND/OR).
//  Each cycle it samples the ALU's operands, opcode, result and carry, and recomputes the
//  expected result and carry. It then counts mismatches, captures the first faulty transaction,
//  and raises a sticky alarm once the mismatch count reaches a threshold.
//  Drives status LEDs and a debug readout for trojan-detection experiments.
// PARAMETERS
//  WIDTH         4   operand/result width (ALU is 4-bit)
//  CNT_W         8   width of err_count and txn_count (both saturating)
//  ALARM_THRESH  3   mismatches needed to enter ALARM (1..2^CNT_W-1)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  clear        in   1      synchronous clear of counters/capture/FSM/pipeline
//  in_valid     in   1      a transaction is present this cycle
//  in_a         in   WIDTH  ALU operand a
//  in_b         in   WIDTH  ALU operand b
//  in_op        in   2      opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
//  in_res       in   WIDTH  ALU result under test
//  in_cout      in   1      ALU carry/borrow under test
//  chk_valid    out  1      one checked transaction is reported this cycle
//  chk_mismatch out  1      qualified by chk_valid: result or carry differed
//  err_count    out  CNT_W  mismatches since reset/clear, saturating
//  txn_count    out  CNT_W  checked transactions since reset/clear, saturating
//  state        out  2      00 CLEAN, 01 SUSPECT, 10 ALARM
//  alarm        out  1      equals (state == ALARM)
//  cap_valid    out  1      the capture registers hold the first mismatch
//  cap_a/cap_b  out  WIDTH  operands of the first mismatch
//  cap_op       out  2      opcode of the first mismatch
//  cap_res      out  WIDTH  faulty result of the first mismatch
//  cap_cout     out  1      faulty carry of the first mismatch
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): every output and pipeline register goes to 0; state = CLEAN.
//  Pipeline, 2 stages, fully pipelined, one transaction per cycle:
//   - S1 registers the inputs when in_valid=1.
//   - S2 compares and registers chk_valid/chk_mismatch.
//   - in_valid sampled at edge N -> chk_valid high after edge N+2.
//   - Counters, capture and FSM also update at edge N+2.
//   - No in_valid -> no chk_valid and no counter change.
//  Golden model (all arithmetic is WIDTH+1 bits wide):
//   - ADD: {exp_cout, exp_res} = a + b
//   - SUB: exp_res = (a - b) mod 2^WIDTH; exp_cout = (a < b), i.e. borrow
//   - AND: exp_res = a & b; exp_cout = 0
//   - OR:  exp_res = a | b; exp_cout = 0
//   - mismatch = (in_res != exp_res) || (in_cout != exp_cout)
//  Counters:
//   - txn_count increments on each chk_valid.
//   - err_count increments on each chk_valid with chk_mismatch.
//   - Both hold at all-ones; they never wrap.
//  Capture:
//   - Loads on the first mismatch while cap_valid=0, then sets cap_valid.
//   - Later mismatches never overwrite it.
//  FSM (evaluated on the updated err_count):
//   - CLEAN -> SUSPECT on the first mismatch.
//   - SUSPECT -> ALARM when err_count reaches ALARM_THRESH.
//   - If ALARM_THRESH = 1: CLEAN -> ALARM directly.
//   - ALARM is sticky; only rst or clear leaves it. No other transitions.
//  clear:
//   - Same effect as rst on counters, capture, FSM and both pipeline stages.
//   - In-flight transactions are discarded and never reported.
//   - If clear coincides with an S2 mismatch, clear wins and the mismatch is not counted.
//  Priority: rst > clear > normal operation.
//  Reset mid-operation: in-flight S1/S2 data is dropped; no chk_valid follows.
// TESTING
//  1. ADD a=5 b=3 res=8 cout=0 -> chk_valid 2 cycles later, mismatch=0, txn=1, err=0, CLEAN.
//  2. SUB a=3 b=5 res=14 cout=1 -> mismatch=0.
//     ADD a=15 b=15 res=15 cout=0 -> mismatch=1, err=1, SUSPECT, cap={15,15,00,15,0}.
//  3. Send ADD 9+6 res=5 cout=1, then OR 3|12 res=15 cout=1, then AND 15&15 res=14 cout=1,
//     back-to-back -> three consecutive chk_valid; alarm rises with the 3rd (THRESH=3);
//     the capture keeps the first mismatch.
//  4. Assert clear in the same cycle a mismatch reaches S2 -> err=0, txn=0, CLEAN,
//     cap_valid=0, no chk_valid next cycle.
//  5. 300 correct transactions with CNT_W=8 -> txn_count saturates at 255, err_count stays 0.
//  6. Assert rst with two transactions in flight -> all outputs 0 next cycle,
//     no chk_valid for those transactions.

Source files
------------

// File: rtl/alu_chk_if.sv
// Bundle between the 4-bit ALU under test and its golden-model result checker.
// The master side drives the observed transaction; the slave side is the checker.
interface alu_chk_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_res;
  logic             in_cout;

  logic             chk_valid;
  logic             chk_mismatch;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] txn_count;
  logic [1:0]       state;
  logic             alarm;
  logic             cap_valid;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [1:0]       cap_op;
  logic [WIDTH-1:0] cap_res;
  logic             cap_cout;

  modport master (
    output clear, in_valid, in_a, in_b, in_op, in_res, in_cout,
    input  chk_valid, chk_mismatch, err_count, txn_count, state, alarm,
           cap_valid, cap_a, cap_b, cap_op, cap_res, cap_cout
  );

  modport slave (
    input  clear, in_valid, in_a, in_b, in_op, in_res, in_cout,
    output chk_valid, chk_mismatch, err_count, txn_count, state, alarm,
           cap_valid, cap_a, cap_b, cap_op, cap_res, cap_cout
  );
endinterface

// File: rtl/alu_result_checker.sv
// Golden-model checker for the 4-bit ADD/SUB/AND/OR ALU: recomputes result/carry,
// counts mismatches, captures the first faulty transaction and raises a sticky alarm.
module alu_result_checker #(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 3
) (
  input  logic      clk,
  input  logic      rst,
  alu_chk_if.slave  bus
);
  localparam logic [1:0]       ST_CLEAN   = 2'b00;
  localparam logic [1:0]       ST_SUSPECT = 2'b01;
  localparam logic [1:0]       ST_ALARM   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(ALARM_THRESH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [WIDTH-1:0] res;
    logic             cout;
  } txn_t;

  // [0] S1 holds a txn, [1] S2 holds a compared txn, [2] chk_valid
  logic [2:0]       r_vld_pipe;
  txn_t             r_s1;
  txn_t             r_s2;
  logic             r_s2_mis;
  logic             r_chk_mismatch;

  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_txn_count;
  logic [1:0]       r_state;
  logic             r_cap_valid;
  txn_t             r_cap;

  txn_t             w_in;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_exp;
  logic             w_mis;
  logic             w_hit;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_txn_nxt;
  logic [1:0]       w_state_nxt;

  assign w_in = '{a: bus.in_a, b: bus.in_b, op: bus.in_op, res: bus.in_res, cout: bus.in_cout};

  // Golden model; SUB borrow falls out as the top bit of the WIDTH+1 difference.
  always_comb begin
    w_sum  = {1'b0, r_s1.a} + {1'b0, r_s1.b};
    w_diff = {1'b0, r_s1.a} - {1'b0, r_s1.b};
    w_exp  = '0;
    case (r_s1.op)
      OP_ADD:  w_exp = w_sum;
      OP_SUB:  w_exp = w_diff;
      OP_AND:  w_exp = {1'b0, r_s1.a & r_s1.b};
      default: w_exp = {1'b0, r_s1.a | r_s1.b};
    endcase
  end

  assign w_mis = (r_s1.res != w_exp[WIDTH-1:0]) || (r_s1.cout != w_exp[WIDTH]);

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_vld_pipe     <= '0;
      r_s1           <= '0;
      r_s2           <= '0;
      r_s2_mis       <= 1'b0;
      r_chk_mismatch <= 1'b0;
    end else begin
      r_vld_pipe     <= {r_vld_pipe[1:0], bus.in_valid};
      r_chk_mismatch <= r_vld_pipe[1] & r_s2_mis;
      if (bus.in_valid)
        r_s1 <= w_in;
      if (r_vld_pipe[0]) begin
        r_s2     <= r_s1;
        r_s2_mis <= w_mis;
      end
    end
  end

  assign w_hit     = r_vld_pipe[1] & r_s2_mis;
  assign w_txn_nxt = (r_vld_pipe[1] && r_txn_count != CNT_MAX) ? r_txn_count + 1'b1 : r_txn_count;
  assign w_err_nxt = (w_hit && r_err_count != CNT_MAX) ? r_err_count + 1'b1 : r_err_count;

  // State decisions look at the post-increment error count.
  always_comb begin
    w_state_nxt = r_state;
    if (w_hit) begin
      case (r_state)
        ST_CLEAN:   w_state_nxt = (w_err_nxt >= THRESH) ? ST_ALARM : ST_SUSPECT;
        ST_SUSPECT: if (w_err_nxt >= THRESH) w_state_nxt = ST_ALARM;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_err_count <= '0;
      r_txn_count <= '0;
      r_state     <= ST_CLEAN;
      r_cap_valid <= 1'b0;
      r_cap       <= '0;
    end else begin
      r_err_count <= w_err_nxt;
      r_txn_count <= w_txn_nxt;
      r_state     <= w_state_nxt;
      if (w_hit && !r_cap_valid) begin
        r_cap       <= r_s2;
        r_cap_valid <= 1'b1;
      end
    end
  end

  assign bus.chk_valid    = r_vld_pipe[2];
  assign bus.chk_mismatch = r_chk_mismatch;
  assign bus.err_count    = r_err_count;
  assign bus.txn_count    = r_txn_count;
  assign bus.state        = r_state;
  assign bus.alarm        = (r_state == ST_ALARM);
  assign bus.cap_valid    = r_cap_valid;
  assign bus.cap_a        = r_cap.a;
  assign bus.cap_b        = r_cap.b;
  assign bus.cap_op       = r_cap.op;
  assign bus.cap_res      = r_cap.res;
  assign bus.cap_cout     = r_cap.cout;
endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: expected verdicts queued at drive time,
// popped and compared (with a reference counter/FSM/capture model) on each chk_valid.
module tb_alu_result_checker;
  localparam int W  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_chk_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  alu_result_checker #(.WIDTH(W), .CNT_W(CW), .ALARM_THRESH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic       cout;
    logic       mis;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          m_txn, m_err;
  logic        m_cv;
  logic [14:0] m_cap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] gold(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int ia, ib, r;
    logic [3:0] r4;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0: begin r = ia + ib; r4 = r[3:0]; return {r > 15, r4}; end
      2'd1: begin r = (ia - ib + 16) % 16; r4 = r[3:0]; return {ia < ib, r4}; end
      2'd2: return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  function automatic logic [1:0] model_state(input int err);
    if (err == 0) return 2'd0;
    if (err >= 3) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [14:0] cap_bus();
    return {bus.cap_a, bus.cap_b, bus.cap_op, bus.cap_res, bus.cap_cout};
  endfunction

  function automatic logic [63:0] all_outs();
    return {27'd0, bus.chk_valid, bus.chk_mismatch, bus.err_count, bus.txn_count,
            bus.state, bus.alarm, bus.cap_valid, cap_bus()};
  endfunction

  task automatic flush_model();
    sb.delete();
    m_txn = 0;
    m_err = 0;
    m_cv  = 1'b0;
    m_cap = '0;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic [3:0] res, input logic cout);
    exp_t x;
    logic [4:0] g;
    g = gold(a, b, op);
    x.a = a; x.b = b; x.op = op; x.res = res; x.cout = cout;
    x.mis = ({cout, res} != g);
    x.cyc = cyc;
    sb.push_back(x);
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_res = res; bus.in_cout = cout;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 12) begin @(posedge clk); #1; k++; end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    flush_model();
  endtask

  // Monitor: every reported check must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.chk_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_chk_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("chk_mismatch", 64'(bus.chk_mismatch), 64'(e.mis));
        chk("latency", 64'(cyc - e.cyc), 64'd3);
        if (m_txn < 255) m_txn++;
        if (e.mis) begin
          if (m_err < 255) m_err++;
          if (!m_cv) begin
            m_cv  = 1'b1;
            m_cap = {e.a, e.b, e.op, e.res, e.cout};
          end
        end
        chk("txn_count", 64'(bus.txn_count), 64'(m_txn));
        chk("err_count", 64'(bus.err_count), 64'(m_err));
        chk("state", 64'(bus.state), 64'(model_state(m_err)));
        chk("alarm", 64'(bus.alarm), 64'(model_state(m_err) == 2'd2));
        chk("cap_valid", 64'(bus.cap_valid), 64'(m_cv));
        chk("capture", 64'(cap_bus()), 64'(m_cap));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a, b;
    logic [1:0] op;
    logic [4:0] g;
    rst = 1'b1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_res = '0; bus.in_cout = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", all_outputs_or_zero(), 64'd0);

    // 1: single correct ADD
    send(4'd5, 4'd3, 2'b00, 4'd8, 1'b0);
    drain();
    chk("t1_txn", 64'(bus.txn_count), 64'd1);
    chk("t1_state", 64'(bus.state), 64'd0);

    // 2: SUB with borrow is fine; ADD 15+15 reported wrong
    send(4'd3, 4'd5, 2'b01, 4'd14, 1'b1);
    send(4'd15, 4'd15, 2'b00, 4'd15, 1'b0);
    drain();
    chk("t2_err", 64'(bus.err_count), 64'd1);
    chk("t2_state", 64'(bus.state), 64'd1);
    chk("t2_cap", 64'(cap_bus()), 64'({4'd15, 4'd15, 2'b00, 4'd15, 1'b0}));

    // 3: three back-to-back faults from a clean slate
    do_clear();
    send(4'd9, 4'd6, 2'b00, 4'd5, 1'b1);
    send(4'd3, 4'd12, 2'b11, 4'd15, 1'b1);
    send(4'd15, 4'd15, 2'b10, 4'd14, 1'b1);
    drain();
    chk("t3_alarm", 64'(bus.alarm), 64'd1);
    chk("t3_err", 64'(bus.err_count), 64'd3);
    chk("t3_cap", 64'(cap_bus()), 64'({4'd9, 4'd6, 2'b00, 4'd5, 1'b1}));

    // 4: clear lands on the edge the mismatch would be reported
    send(4'd1, 4'd1, 2'b00, 4'd7, 1'b0);
    idle(1);
    do_clear();
    chk("t4_err", 64'(bus.err_count), 64'd0);
    chk("t4_txn", 64'(bus.txn_count), 64'd0);
    chk("t4_state", 64'(bus.state), 64'd0);
    chk("t4_cap_valid", 64'(bus.cap_valid), 64'd0);
    @(negedge clk);
    chk("t4_no_chk_valid", 64'(bus.chk_valid), 64'd0);
    @(posedge clk); #1;
    idle(3);

    // 5: saturation of the transaction counter
    for (int i = 0; i < 300; i++) begin
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      g  = gold(a, b, op);
      send(a, b, op, g[3:0], g[4]);
    end
    drain();
    chk("t5_txn_sat", 64'(bus.txn_count), 64'd255);
    chk("t5_err", 64'(bus.err_count), 64'd0);

    // 6: reset with two transactions in flight
    send(4'd2, 4'd2, 2'b00, 4'd0, 1'b0);
    send(4'd7, 4'd1, 2'b01, 4'd6, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush_model();
    chk("t6_outputs_zero", all_outputs_or_zero(), 64'd0);
    idle(4);
    send(4'd6, 4'd9, 2'b01, 4'd13, 1'b1);
    drain();
    chk("t6_recover_txn", 64'(bus.txn_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  function automatic logic [63:0] all_outputs_or_zero();
    return all_outs();
  endfunction
endmodule
